// File: rtl/data_mem_pkg.sv
// ============================================================================
// Module : data_mem_pkg
// Shared memory commands, arbiter FSM states and default widths.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package data_mem_pkg;

  localparam int ADDR_LENGTH = 11;
  localparam int DATA_LENGTH = 16;

  localparam logic [1:0] MEM_WRITE = 2'b10;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_NOP   = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Only real reads and writes reach the memory; 00/11 become no-ops.
  function automatic logic is_mem_cmd(input logic [1:0] cmd);
    return (cmd == MEM_WRITE) || (cmd == MEM_READ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Two-way combinational grant. DEBUG_PRIORITY_EN selects fixed port-1 priority.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic p0_req,
  input  logic p1_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

`ifdef DEBUG_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_valid = p0_req | p1_req;
    grant_id    = p1_req;
  end
`else
  always_comb begin
    grant_valid = p0_req | p1_req;
    if (p0_req && p1_req)
      grant_id = ~last_grant;
    else
      grant_id = p1_req;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ============================================================================
// Module : data_mem_arbiter
// Two-port arbiter/sequencer for the negedge single-port data memory.
// Optional macro DEBUG_PRIORITY_EN gives port 1 fixed priority.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module data_mem_arbiter #(
  parameter int ADDR_LENGTH = data_mem_pkg::ADDR_LENGTH,
  parameter int DATA_LENGTH = data_mem_pkg::DATA_LENGTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   p0_req,
  input  logic [1:0]             p0_wrrd,
  input  logic [ADDR_LENGTH-1:0] p0_addr,
  input  logic [DATA_LENGTH-1:0] p0_wdata,
  output logic                   p0_ack,
  output logic [DATA_LENGTH-1:0] p0_rdata,
  input  logic                   p1_req,
  input  logic [1:0]             p1_wrrd,
  input  logic [ADDR_LENGTH-1:0] p1_addr,
  input  logic [DATA_LENGTH-1:0] p1_wdata,
  output logic                   p1_ack,
  output logic [DATA_LENGTH-1:0] p1_rdata,
  output logic [1:0]             mem_wrrd,
  output logic [ADDR_LENGTH-1:0] mem_addr,
  output logic [DATA_LENGTH-1:0] mem_wdata,
  input  logic [DATA_LENGTH-1:0] mem_rdata,
  output logic                   busy,
  output logic                   grant_id
);

  import data_mem_pkg::*;

  state_t                 state, state_nxt;
  logic                   last_grant, last_grant_nxt;
  logic                   grant_valid, win;
  logic [1:0]             win_wrrd;
  logic [ADDR_LENGTH-1:0] win_addr;
  logic [DATA_LENGTH-1:0] win_wdata;

  logic [1:0]             mem_wrrd_nxt;
  logic [ADDR_LENGTH-1:0] mem_addr_nxt;
  logic [DATA_LENGTH-1:0] mem_wdata_nxt;
  logic [DATA_LENGTH-1:0] p0_rdata_nxt, p1_rdata_nxt;
  logic                   p0_ack_nxt, p1_ack_nxt, busy_nxt, grant_id_nxt;

  rr_arb2 u_arb (
    .p0_req      (p0_req),
    .p1_req      (p1_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (win)
  );

  assign win_wrrd  = win ? p1_wrrd  : p0_wrrd;
  assign win_addr  = win ? p1_addr  : p0_addr;
  assign win_wdata = win ? p1_wdata : p0_wdata;

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_id_nxt   = grant_id;
    mem_wrrd_nxt   = mem_wrrd;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    p0_rdata_nxt   = p0_rdata;
    p1_rdata_nxt   = p1_rdata;
    p0_ack_nxt     = 1'b0;
    p1_ack_nxt     = 1'b0;
    busy_nxt       = busy;

    case (state)
      ST_IDLE: begin
        mem_wrrd_nxt = MEM_NOP;
        if (grant_valid) begin
          grant_id_nxt   = win;
          last_grant_nxt = win;
          mem_wrrd_nxt   = is_mem_cmd(win_wrrd) ? win_wrrd : MEM_NOP;
          mem_addr_nxt   = win_addr;
          mem_wdata_nxt  = win_wdata;
          busy_nxt       = 1'b1;
          state_nxt      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Memory has executed on the preceding negedge; mem_rdata is valid now.
        if (mem_wrrd == MEM_READ) begin
          if (grant_id)
            p1_rdata_nxt = mem_rdata;
          else
            p0_rdata_nxt = mem_rdata;
        end
        p0_ack_nxt   = ~grant_id;
        p1_ack_nxt   = grant_id;
        mem_wrrd_nxt = MEM_NOP;
        state_nxt    = ST_DONE;
      end
      ST_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: begin
        mem_wrrd_nxt = MEM_NOP;
        busy_nxt     = 1'b0;
        state_nxt    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      mem_wrrd   <= MEM_NOP;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant_id   <= grant_id_nxt;
      mem_wrrd   <= mem_wrrd_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      p0_rdata   <= p0_rdata_nxt;
      p1_rdata   <= p1_rdata_nxt;
      p0_ack     <= p0_ack_nxt;
      p1_ack     <= p1_ack_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ============================================================================
// Module : tb_data_mem_arbiter
// Directed bench for data_mem_arbiter with a negedge memory model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_arbiter;

`ifdef DEBUG_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p1_req;
  logic [1:0]  p0_wrrd, p1_wrrd;
  logic [10:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [15:0] p0_rdata, p1_rdata;
  logic [1:0]  mem_wrrd;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        busy, grant_id;

  logic [15:0] mem [0:2047];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .p0_req    (p0_req),
    .p0_wrrd   (p0_wrrd),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_ack    (p0_ack),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_wrrd   (p1_wrrd),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_ack    (p1_ack),
    .p1_rdata  (p1_rdata),
    .mem_wrrd  (mem_wrrd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  // Data memory: acts on the falling edge.
  always @(negedge clk) begin
    if (mem_wrrd == 2'b10)
      mem[mem_addr] <= mem_wdata;
    else if (mem_wrrd == 2'b01)
      mem_rdata <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle values for the back-to-back alternation run.
  logic [8:0] exp_gnt, exp_a0, exp_a1;
  logic       prev_ack;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'(i);
    reset = 1'b1;
    p0_req = 0; p0_wrrd = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_wrrd = 0; p1_addr = 0; p1_wdata = 0;

    // Reset state
    tick(); tick();
    check("rst_mem_wrrd", 32'(mem_wrrd), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_acks", {30'd0, p1_ack, p0_ack}, 0);
    check("rst_rdata", {p1_rdata, p0_rdata}, 0);
    check("rst_busy_gnt", {30'd0, busy, grant_id}, 0);
    reset = 1'b0;

    // p0 read addr 5
    p0_req = 1; p0_wrrd = 2'b01; p0_addr = 11'd5;
    tick();
    check("rd5_e0_wrrd", 32'(mem_wrrd), 32'h1);
    check("rd5_e0_addr", 32'(mem_addr), 32'd5);
    check("rd5_e0_busy", 32'(busy), 1);
    check("rd5_e0_ack", 32'(p0_ack), 0);
    tick();
    check("rd5_e1_ack", 32'(p0_ack), 1);
    check("rd5_e1_rdata", 32'(p0_rdata), 32'h0005);
    check("rd5_e1_wrrd", 32'(mem_wrrd), 0);
    p0_req = 0;
    tick();
    check("rd5_e2_ack", 32'(p0_ack), 0);
    check("rd5_e2_busy", 32'(busy), 0);

    // p1 write addr 7, then p0 read addr 7
    p1_req = 1; p1_wrrd = 2'b10; p1_addr = 11'd7; p1_wdata = 16'hBEEF;
    tick();
    check("wr7_gnt", 32'(grant_id), 1);
    check("wr7_wrrd", 32'(mem_wrrd), 32'h2);
    check("wr7_wdata", 32'(mem_wdata), 32'hBEEF);
    tick();
    check("wr7_ack", 32'(p1_ack), 1);
    check("wr7_rdata", 32'(p1_rdata), 0);
    p1_req = 0;
    tick();
    check("wr7_ack_off", 32'(p1_ack), 0);
    p0_req = 1; p0_wrrd = 2'b01; p0_addr = 11'd7;
    tick(); tick();
    check("rd7_ack", 32'(p0_ack), 1);
    check("rd7_rdata", 32'(p0_rdata), 32'hBEEF);
    p0_req = 0;
    tick();

    // Simultaneous reads after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    p0_req = 1; p0_wrrd = 2'b01; p0_addr = 11'd1;
    p1_req = 1; p1_wrrd = 2'b01; p1_addr = 11'd2;
    tick();
    check("tie_first_gnt", 32'(grant_id), 32'(PRIO));
    check("tie_first_addr", 32'(mem_addr), PRIO ? 32'd2 : 32'd1);
    tick();
    check("tie_first_acks", {30'd0, p1_ack, p0_ack}, PRIO ? 32'h2 : 32'h1);
    if (PRIO) p1_req = 0; else p0_req = 0;
    tick(); tick();
    check("tie_second_gnt", 32'(grant_id), 32'(!PRIO));
    tick();
    check("tie_second_acks", {30'd0, p1_ack, p0_ack}, PRIO ? 32'h1 : 32'h2);
    p0_req = 0; p1_req = 0;
    check("tie_p0_rdata", 32'(p0_rdata), 32'h0001);
    check("tie_p1_rdata", 32'(p1_rdata), 32'h0002);
    tick();

    // Illegal command 2'b11 is a no-op
    p0_req = 1; p0_wrrd = 2'b11; p0_addr = 11'd7; p0_wdata = 16'h1234;
    tick();
    check("nop_wrrd", 32'(mem_wrrd), 0);
    check("nop_busy", 32'(busy), 1);
    tick();
    check("nop_ack", 32'(p0_ack), 1);
    check("nop_rdata", 32'(p0_rdata), 32'h0001);
    p0_req = 0;
    tick();
    p0_req = 1; p0_wrrd = 2'b01; p0_addr = 11'd7;
    tick(); tick();
    check("nop_mem_kept", 32'(p0_rdata), 32'hBEEF);
    p0_req = 0;
    tick();

    // Reset during BUSY of a p0 read
    p0_req = 1; p0_wrrd = 2'b01; p0_addr = 11'd3;
    tick();
    check("rstmid_busy", 32'(busy), 1);
    #1 reset = 1'b1;
    #1;
    check("rstmid_async", {busy, grant_id, p0_ack, p1_ack, mem_wrrd, 26'd0}, 0);
    check("rstmid_regs", {p0_rdata, 5'd0, mem_addr}, 0);
    p0_req = 0;
    tick();
    check("rstmid_noack_a", 32'(p0_ack), 0);
    tick();
    check("rstmid_noack_b", 32'(p0_ack), 0);
    reset = 1'b0;
    p0_req = 1;
    tick(); tick();
    check("rstmid_after_ack", 32'(p0_ack), 1);
    check("rstmid_after_rdata", 32'(p0_rdata), 32'h0003);
    p0_req = 0;
    tick();

    // p0 holds req for three accesses; p1 joins one cycle later and holds.
    // Index i is cycle i+1 after p0 asserts.
    exp_gnt = {PRIO, PRIO, PRIO, 3'b111, 3'b000};
    exp_a0  = {1'b0, !PRIO, 1'b0, 3'b000, 3'b010};
    exp_a1  = {1'b0, PRIO, 1'b0, 3'b010, 3'b000};
    p0_req = 1; p0_wrrd = 2'b01; p0_addr = 11'd10;
    p1_wrrd = 2'b01; p1_addr = 11'd11;
    prev_ack = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      p1_req = 1;
      check($sformatf("alt_gnt_%0d", i), 32'(grant_id), 32'(exp_gnt[i]));
      check($sformatf("alt_acks_%0d", i), {30'd0, p1_ack, p0_ack}, {30'd0, exp_a1[i], exp_a0[i]});
      check($sformatf("alt_ack_run_%0d", i), 32'(prev_ack & (p0_ack | p1_ack)), 0);
      prev_ack = p0_ack | p1_ack;
    end
    p0_req = 0; p1_req = 0;
    check("alt_p0_rdata", 32'(p0_rdata), 32'd10);
    check("alt_p1_rdata", 32'(p1_rdata), 32'd11);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
